// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ins_fetch_pkg;

    // Fetch FSM: IDLE for the first cycle after reset, then FETCH forever.
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // Output buffer depth (the buffer is built for exactly two entries).
    localparam int FETCH_FIFO_DEPTH = 2;

    // First fetch address after reset unless overridden.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/ins_fetch_fifo.sv
// Two-entry in-order buffer between instruction memory and decode.
// Push and pop may happen in the same cycle; flush empties it at once.
// Pushes into a full buffer (without a pop) and pops from an empty one are
// ignored so the buffer can never overflow or duplicate an entry.
module ins_fetch_fifo
    import ins_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Buffer state registers; storage is cleared so the head reads zero in reset.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: issues sequential fetches, captures the returned
// word one cycle later into a two-entry buffer, and presents the buffer head
// to decode. A redirect flushes everything and restarts fetch at the target.
// Decode handshake: a transfer happens at a posedge where dec_vld and dec_rdy
// are both high; dec_pc/dec_ins hold steady while dec_vld is high and
// dec_rdy is low.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [15:0] ins_a,
    output logic        ins_e,
    input  logic [31:0] ins,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc,
    output logic        dec_vld,
    input  logic        dec_rdy,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_ins
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         pop;
    logic         push;
    logic [2:0]   occupancy;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;
    logic         unused_redirect_lsbs;

    // Only word-aligned targets are fetched; the low address bits are dropped.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // FSM next state, fetch issue decision, pc / in-flight bookkeeping.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        pop        = dec_vld & dec_rdy;
        // Slots already spoken for after this cycle's decode transfer.
        occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        ins_e      = (state_q == FETCH) && !redirect_e
                     && (occupancy < 3'(FIFO_DEPTH));
        inflight_d = ins_e;
        // A returning word is dropped if a redirect lands in its capture cycle.
        push       = inflight_q & ~redirect_e;
        push_entry = '{pc: req_pc_q, ins: ins};

        if (state_q == IDLE) begin
            state_d = FETCH;
        end

        if (redirect_e) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (ins_e) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
        end
    end

    ins_fetch_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_e),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign ins_a   = pc_q[15:0];
    assign dec_vld = (fifo_count != 2'd0);
    assign dec_pc  = fifo_head.pc;
    assign dec_ins = fifo_head.ins;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of output buffer entries (fixed at 2).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rstn  input  1  reset, asynchronous, active-high.
REQ-005 ins_a  output  16  instruction memory byte address; equals pc[15:0].
REQ-006 ins_e  output  1  fetch request; memory samples ins_a and ins_e at posedge.
REQ-007 ins  input  32  instruction word, valid in the cycle after the request was sampled.
REQ-008 redirect_e  input  1  control-flow redirect strobe (jump, branch).
REQ-009 redirect_pc  input  32  redirect target address.
REQ-010 dec_vld  output  1  an instruction is presented to decode.
REQ-011 dec_rdy  input  1  decode accepts; a transfer occurs when dec_vld and dec_rdy are both high at posedge.
REQ-012 dec_pc  output  32  PC of the presented instruction.
REQ-013 dec_ins  output  32  presented instruction word.

Function
REQ-014 SHALL keep a 32-bit pc that advances by 4 on each issued request and wraps modulo 2^32; ins_a wraps modulo 2^16.
REQ-015 SHALL use the FSM states IDLE (the first cycle after reset release, no request) and FETCH; the only transition is IDLE->FETCH, and reset returns the FSM to IDLE.
REQ-016 In FETCH, SHALL assert ins_e only when (fifo_count + inflight - pop) < 2, where pop = dec_vld & dec_rdy.
REQ-017 SHALL hold inflight = 1 in the cycle after an issued request and capture ins together with the request pc into the FIFO at the end of that cycle; there is no bypass path.
REQ-018 Request-to-dec_vld latency SHALL be 2 cycles: a request in cycle N gives dec_vld in cycle N+2.
REQ-019 With dec_rdy held high, SHALL sustain one instruction per cycle.
REQ-020 The FIFO SHALL support push and pop in the same cycle, preserve order, never overflow, and never duplicate or drop an entry except by flush.
REQ-021 dec_vld SHALL equal FIFO non-empty; dec_pc and dec_ins SHALL come from the FIFO head and stay stable while dec_vld is high and dec_rdy is low.
REQ-022 On redirect_e, SHALL at that posedge flush the FIFO, discard any in-flight return, and set pc to {redirect_pc[31:2],2'b00}.
REQ-023 Under REQ-022, ins_e SHALL be low in the redirect cycle and the next ins_e SHALL carry the new pc in the following cycle.
REQ-024 When a redirect and a decode transfer coincide, the transfer SHALL count as accepted, and dec_vld SHALL be low in the next cycle.
REQ-025 When redirect_e is asserted while in IDLE, pc SHALL be updated and the FSM SHALL still enter FETCH.

Reset
REQ-026 While rstn is high, the block SHALL asynchronously force: ins_e=0, ins_a=RESET_PC[15:0], dec_vld=0, dec_pc=0, dec_ins=0, FIFO empty, inflight=0, pc=RESET_PC, FSM=IDLE.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions.
REQ-028 After reset release, the first request SHALL appear in the cycle after IDLE, with ins_a=RESET_PC[15:0].

Structure
REQ-029 Package ins_fetch_pkg SHALL hold the FSM state enum, the FIFO_DEPTH constant and the default RESET_PC.
REQ-030 The output buffer SHALL be a separate sub-module, ins_fetch_fifo: 2 entries of {pc[31:0], ins[31:0]}, with push, pop, flush and count.

Verification
REQ-031 Reset release with dec_rdy=1 and memory words 0-3 = 32'h00000013: ins_a goes 0000,0004,0008,000C on consecutive cycles; the first dec_vld comes 2 cycles after the first ins_e with dec_pc=0, dec_ins=00000013.
REQ-032 dec_rdy=0 for 6 cycles during streaming: at most 2 entries buffered, ins_e stays low when full, dec_pc/dec_ins held; after release, dec_pc continues in strict +4 order with no gaps.
REQ-033 redirect_e=1, redirect_pc=32'h00000102 one cycle after a request: the in-flight word is dropped; the next ins_a is 0100; the next dec_pc is 00000100; dec_vld is low in the cycle after the redirect.
REQ-034 RESET_PC=32'h0000FFFC: ins_a goes FFFC then 0000; dec_pc goes 0000FFFC then 00010000.
REQ-035 rstn asserted with 2 entries buffered: dec_vld and ins_e go low before the next clock edge; after release the sequence restarts at RESET_PC.
REQ-036 redirect_e coincides with a decode transfer: the head entry is consumed once, no stale entry appears afterward, and the first new dec_pc equals the redirect target.
